// File: rtl/fill_seq.sv
// Address/data fill sequencer: on a start pulse, emits DEPTH valid/ready beats at
// addresses 0..DEPTH-1 carrying a constant value, then pulses oDone for one cycle.
module fill_seq #(
    parameter int unsigned       DEPTH      = 16,
    parameter int unsigned       ADDR_W     = 8,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              iStart,
    input  logic              iReady,
    output logic              oValid,
    output logic [ADDR_W-1:0] oAddr,
    output logic [DATA_W-1:0] oData,
    output logic              oBusy,
    output logic              oDone
);

    localparam int unsigned      CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDone
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // All outputs are registered, so oValid never depends combinationally on iReady.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            oValid  <= 1'b0;
            oAddr   <= '0;
            oData   <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        state_q <= StFill;
                        cnt_q   <= '0;
                        oValid  <= 1'b1;
                        oAddr   <= '0;
                        oData   <= FILL_VALUE;
                        oBusy   <= 1'b1;
                    end
                end
                StFill: begin
                    if (iReady) begin
                        if (cnt_q == LAST) begin
                            // Last beat taken: counter stays put, outputs drop to zero.
                            state_q <= StDone;
                            oValid  <= 1'b0;
                            oAddr   <= '0;
                            oData   <= '0;
                            oDone   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                            oAddr <= ADDR_W'(cnt_inc);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    oBusy   <= 1'b0;
                    oDone   <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    oValid  <= 1'b0;
                    oAddr   <= '0;
                    oData   <= '0;
                    oBusy   <= 1'b0;
                    oDone   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fill_seq.md
FILL_SEQ -- requirements
Module: fill_seq

Interface
- REQ-001 Parameters, one per line: name, default, meaning.
  - DEPTH, 16, number of fill beats per start; legal range 1..2**ADDR_W.
  - ADDR_W, 8, width of the beat address.
  - DATA_W, 32, width of the fill data.
  - FILL_VALUE, 0, constant data driven on every beat.
- REQ-002 Ports, one per line: name, direction, width, meaning.
  - aclk, in, 1, the single clock; all logic on the rising edge.
  - areset, in, 1, synchronous, active-high reset.
  - iStart, in, 1, start pulse, taken from the 5-cycle start-delay stage output.
  - iReady, in, 1, downstream ready to accept a beat.
  - oValid, out, 1, beat valid.
  - oAddr, out, ADDR_W, beat address.
  - oData, out, DATA_W, beat data.
  - oBusy, out, 1, sequence in progress.
  - oDone, out, 1, one-cycle completion pulse.
- REQ-003 The block SHALL use one clock (aclk) with a synchronous, active-high reset (areset); no other clock or reset SHALL exist.

Function
- REQ-004 The block SHALL implement a 3-state FSM with states IDLE, FILL and DONE.
- REQ-005 IDLE: oValid=0, oBusy=0, oDone=0; iStart=1 sampled on an edge SHALL move the FSM to FILL on that edge, with beat counter=0.
- REQ-006 FILL: oValid=1, oBusy=1, oAddr=counter (zero-extended to ADDR_W), oData=FILL_VALUE.
- REQ-007 A beat SHALL be accepted on an edge where oValid=1 and iReady=1; the counter SHALL increment by 1 per accepted beat.
- REQ-008 While iReady=0 in FILL, oValid, oAddr and oData SHALL hold stable; oValid SHALL NOT depend combinationally on iReady.
- REQ-009 On acceptance of the beat with counter=DEPTH-1, the FSM SHALL go to DONE; the counter SHALL NOT wrap or advance past DEPTH-1.
- REQ-010 DONE SHALL last exactly one cycle, with oDone=1, oBusy=1, oValid=0; then the FSM returns to IDLE unconditionally.
- REQ-011 iStart in FILL or DONE SHALL be ignored, not queued; iStart held high in IDLE SHALL start exactly one sequence per IDLE entry.
- REQ-012 iReady SHALL be ignored while oValid=0.
- REQ-013 Latency with iReady=1 and iStart at edge T:
  - first beat visible after T, i.e. cycle T+1;
  - beats accepted at edges T+1 through T+DEPTH;
  - oDone high in cycle T+DEPTH+1;
  - earliest next start sampled at edge T+DEPTH+2.
- REQ-014 Counter width SHALL be max(1, clog2(DEPTH)); DEPTH=1 SHALL produce a single beat at oAddr=0 followed by DONE.
- REQ-015 oAddr and oData SHALL read 0 whenever oValid=0.

Reset
- REQ-016 areset=1 on an edge SHALL force state=IDLE and counter=0, and drive oValid, oAddr, oData, oBusy and oDone to 0 from the next cycle, overriding all other inputs.
- REQ-017 Reset during FILL or DONE SHALL abort the sequence with no oDone pulse; the first iStart after areset deasserts SHALL start a fresh sequence from address 0.

Verification
- REQ-018 Basic fill:
  - stimulus: DEPTH=16, iReady=1, iStart pulse at edge 10;
  - response: oValid high for cycles 11-26, oAddr 0..15, oData=FILL_VALUE, oDone only in cycle 27, oBusy high in cycles 11-27.
- REQ-019 Backpressure:
  - stimulus: iReady toggled 1,0,0,1,... during FILL;
  - response: oAddr holds while iReady=0, no address skipped or repeated, exactly 16 accepted beats, then one oDone.
- REQ-020 Start while busy:
  - stimulus: extra iStart pulses at the 5th beat and in the DONE cycle;
  - response: both ignored, single sequence, single oDone.
- REQ-021 Reset mid-fill:
  - stimulus: areset=1 for 1 cycle after beat 7;
  - response: all outputs 0 on the next cycle, no oDone; the next iStart produces oAddr 0..15.
- REQ-022 Edge cases:
  - DEPTH=1: one beat at oAddr=0, oDone on the following cycle;
  - iStart held high continuously: back-to-back sequences separated by exactly one IDLE cycle.
